// File: rtl/tree_grng_bit_feeder.sv
// 64-bit xorshift random-bit source feeding the 8-bit tree Gaussian sampler.
// Delivers 56 fresh bits per sample, sliced into eight probability-bit groups, behind valid/ready.
module tree_grng_bit_feeder #(
    parameter logic [63:0] SEED   = 64'h0000_0000_0000_0001,
    parameter int          WARMUP = 16,
    parameter int          CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [63:0]      seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             pbits7,
    output logic             pbits6,
    output logic [1:0]       pbits5,
    output logic [3:0]       pbits4,
    output logic [7:0]       pbits3,
    output logic [15:0]      pbits2,
    output logic [15:0]      pbits1,
    output logic [7:0]       pbits0,
    output logic             busy,
    output logic [CNT_W-1:0] sample_count
);

    generate
        if (SEED == 64'd0) begin : g_bad_seed
            $error("tree_grng_bit_feeder: SEED must be nonzero");
        end
        if (WARMUP < 0) begin : g_bad_warmup
            $error("tree_grng_bit_feeder: WARMUP must be non-negative");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_FILL   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int     WU_W      = (WARMUP < 2) ? 1 : $clog2(WARMUP);
    localparam state_t RST_STATE = (WARMUP == 0) ? ST_FILL : ST_WARMUP;

    function automatic logic [63:0] xorshift_step(input logic [63:0] x);
        logic [63:0] x1;
        logic [63:0] x2;
        x1 = x ^ (x << 13);
        x2 = x1 ^ (x1 >> 7);
        return x2 ^ (x2 << 17);
    endfunction

    state_t            state_q, state_d;
    logic [63:0]       x_q, x_d;
    logic [WU_W-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [55:0]       data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [63:0]       step_x;

    assign step_x = xorshift_step(x_q);

    always_comb begin
        // NOTE: every target gets its hold value first so no path can infer a latch.
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;

        case (state_q)
            ST_WARMUP: begin
                x_d   = step_x;
                cnt_d = cnt_q + WU_W'(1);
                if (cnt_q == WU_W'(WARMUP - 1)) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                x_d     = step_x;
                data_d  = step_x[55:0];
                valid_d = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (valid_q && out_ready) begin
                    x_d     = step_x;
                    data_d  = step_x[55:0];
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = RST_STATE;
        endcase

        // Reseed overrides the generator and flow state, but a coincident transfer still counts.
        if (seed_valid) begin
            x_d     = (seed == 64'd0) ? SEED : seed;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = RST_STATE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            x_q     <= SEED;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign out_valid    = valid_q;
    assign busy         = (state_q != ST_RUN);
    assign sample_count = count_q;

    assign pbits7 = data_q[55];
    assign pbits6 = data_q[54];
    assign pbits5 = data_q[53:52];
    assign pbits4 = data_q[51:48];
    assign pbits3 = data_q[47:40];
    assign pbits2 = data_q[39:24];
    assign pbits1 = data_q[23:8];
    assign pbits0 = data_q[7:0];

endmodule

// File: tb/tb_tree_grng_bit_feeder.sv
// Directed bench: instance a uses defaults (WARMUP=16), instance b uses WARMUP=0 with a 4-bit counter.
module tb_tree_grng_bit_feeder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        seed_valid_a, seed_valid_b;
    logic [63:0] seed_a, seed_b;
    logic        ready_a, ready_b;

    logic        valid_a, busy_a, pa7, pa6;
    logic [1:0]  pa5;
    logic [3:0]  pa4;
    logic [7:0]  pa3, pa0;
    logic [15:0] pa2, pa1;
    logic [31:0] count_a;

    logic        valid_b, busy_b, pb7, pb6;
    logic [1:0]  pb5;
    logic [3:0]  pb4;
    logic [7:0]  pb3, pb0;
    logic [15:0] pb2, pb1;
    logic [3:0]  count_b;

    logic [55:0] data_a, data_b;
    assign data_a = {pa7, pa6, pa5, pa4, pa3, pa2, pa1, pa0};
    assign data_b = {pb7, pb6, pb5, pb4, pb3, pb2, pb1, pb0};

    tree_grng_bit_feeder dut_a (
        .clk(clk), .rst(rst), .seed_valid(seed_valid_a), .seed(seed_a), .out_ready(ready_a),
        .out_valid(valid_a), .pbits7(pa7), .pbits6(pa6), .pbits5(pa5), .pbits4(pa4),
        .pbits3(pa3), .pbits2(pa2), .pbits1(pa1), .pbits0(pa0),
        .busy(busy_a), .sample_count(count_a)
    );

    tree_grng_bit_feeder #(.WARMUP(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .seed_valid(seed_valid_b), .seed(seed_b), .out_ready(ready_b),
        .out_valid(valid_b), .pbits7(pb7), .pbits6(pb6), .pbits5(pb5), .pbits4(pb4),
        .pbits3(pb3), .pbits2(pb2), .pbits1(pb1), .pbits0(pb0),
        .busy(busy_b), .sample_count(count_b)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [63:0] step(input logic [63:0] x);
        logic [63:0] x1;
        logic [63:0] x2;
        x1 = x ^ (x << 13);
        x2 = x1 ^ (x1 >> 7);
        return x2 ^ (x2 << 17);
    endfunction

    function automatic logic [63:0] step_n(input logic [63:0] x, input int n);
        logic [63:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = step(r);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] ma, mb;

    initial begin
        rst = 1'b1;
        seed_valid_a = 1'b0; seed_valid_b = 1'b0;
        seed_a = '0; seed_b = '0;
        ready_a = 1'b0; ready_b = 1'b0;
        tick;
        tick;

        check("rst_valid_a", 64'(valid_a), 64'd0);
        check("rst_busy_a",  64'(busy_a),  64'd1);
        check("rst_count_a", 64'(count_a), 64'd0);
        check("rst_data_a",  64'(data_a),  64'd0);
        check("rst_valid_b", 64'(valid_b), 64'd0);
        check("rst_busy_b",  64'(busy_b),  64'd1);

        // Release reset; dut_b fills on the first edge, dut_a warms up for 16 edges.
        rst = 1'b0;
        ready_b = 1'b1;
        mb = 64'h1;
        for (int k = 1; k <= 17; k++) begin
            tick;
            mb = step(mb);
            if (k == 1) begin
                check("b_first_valid", 64'(valid_b), 64'd1);
                check("b_first_busy",  64'(busy_b),  64'd0);
                check("b_first_s",     64'(data_b),  64'h0000_0000_4082_2041);
                check("b_pbits0", 64'(pb0), 64'h41);
                check("b_pbits1", 64'(pb1), 64'h8220);
                check("b_pbits2", 64'(pb2), 64'h0040);
                check("b_pbits3", 64'(pb3), 64'h0);
                check("b_pbits4", 64'(pb4), 64'h0);
                check("b_pbits5", 64'(pb5), 64'h0);
                check("b_pbits6", 64'(pb6), 64'h0);
                check("b_pbits7", 64'(pb7), 64'h0);
                check("b_count0", 64'(count_b), 64'd0);
            end else begin
                check("b_stream", 64'(data_b), 64'(mb[55:0]));
                check("b_count",  64'(count_b), 64'((k - 1) % 16));
            end
            if (k <= 16) begin
                check("a_warm_valid", 64'(valid_a), 64'd0);
                check("a_warm_busy",  64'(busy_a),  64'd1);
            end
        end
        ready_b = 1'b0;
        check("b_count_wrap", 64'(count_b), 64'd0);

        ma = step_n(64'h1, 17);
        check("a_first_valid", 64'(valid_a), 64'd1);
        check("a_first_busy",  64'(busy_a),  64'd0);
        check("a_first_data",  64'(data_a),  64'(ma[55:0]));

        // Backpressure: ten stalled cycles, then a single-cycle ready pulse.
        for (int i = 0; i < 10; i++) begin
            tick;
            check("bp_data",  64'(data_a),  64'(ma[55:0]));
            check("bp_count", 64'(count_a), 64'd0);
            check("bp_valid", 64'(valid_a), 64'd1);
        end
        ready_a = 1'b1;
        tick;
        ready_a = 1'b0;
        ma = step(ma);
        check("pulse_data",  64'(data_a),  64'(ma[55:0]));
        check("pulse_count", 64'(count_a), 64'd1);
        tick;
        check("post_pulse_data",  64'(data_a),  64'(ma[55:0]));
        check("post_pulse_count", 64'(count_a), 64'd1);

        // Reseed with zero concurrent with a transfer: substitute seed, count still increments.
        seed_a = 64'd0;
        seed_valid_a = 1'b1;
        ready_a = 1'b1;
        tick;
        seed_valid_a = 1'b0;
        check("reseed_valid", 64'(valid_a), 64'd0);
        check("reseed_busy",  64'(busy_a),  64'd1);
        check("reseed_count", 64'(count_a), 64'd2);
        for (int i = 0; i < 16; i++) begin
            tick;
            check("reseed_warm_valid", 64'(valid_a), 64'd0);
        end
        tick;
        ma = step_n(64'h1, 17);
        check("restart_valid", 64'(valid_a), 64'd1);
        check("restart_data",  64'(data_a),  64'(ma[55:0]));
        check("restart_count", 64'(count_a), 64'd2);
        for (int i = 1; i <= 5; i++) begin
            tick;
            ma = step(ma);
            check("restart_stream", 64'(data_a),  64'(ma[55:0]));
            check("restart_cnt",    64'(count_a), 64'(2 + i));
        end

        // Asynchronous reset in the middle of a cycle during RUN.
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(valid_a), 64'd0);
        check("arst_busy",  64'(busy_a),  64'd1);
        check("arst_count", 64'(count_a), 64'd0);
        check("arst_data",  64'(data_a),  64'd0);
        check("arst_count_b", 64'(count_b), 64'd0);
        tick;
        rst = 1'b0;
        ready_a = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tree_grng_bit_feeder.md
# tree_grng_bit_feeder

Uniform random-bit source that sits directly upstream of the 8-bit tree-based Gaussian sampler. It steps a 64-bit xorshift generator and slices 56 fresh bits per sample into the sampler's eight probability-bit groups. The groups are 1, 1, 2, 4, 8, 16, 16 and 8 bits wide. Each sample is held in an output register behind a valid/ready handshake. The block also provides runtime reseeding, a warm-up phase and a delivered-sample counter.

## Interface
- SEED, 64'h0000_0000_0000_0001, reset and substitute seed; 0 is illegal (elaboration error).
- WARMUP, 16, generator steps discarded after reset or reseed; 0 allowed.
- CNT_W, 32, width of sample counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- seed_valid  in  1  one-cycle request to reload the generator.
- seed  in  64  new seed, sampled when seed_valid=1.
- out_ready  in  1  consumer accepts the current sample.
- out_valid  out  1  pbits* hold a valid sample.
- pbits7  out  1  = s[55]
- pbits6  out  1  = s[54]
- pbits5  out  2  = s[53:52]
- pbits4  out  4  = s[51:48]
- pbits3  out  8  = s[47:40]
- pbits2  out  16  = s[39:24]
- pbits1  out  16  = s[23:8]
- pbits0  out  8  = s[7:0]
- busy  out  1  high while not in RUN.
- sample_count  out  CNT_W  number of accepted samples, wrapping.

For every pbits group, the slice MSB drives the consumer's index-0 (leftmost) element.

## Operation
- Generator step: x1 = x ^ (x<<13); x2 = x1 ^ (x1>>7); step(x) = x2 ^ (x2<<17). All shifts are logical and truncated to 64 bits. s denotes step(x) at the moment of loading.
- The output register holds a 56-bit slice of s. The top 8 bits of s are discarded.
- FSM states:
  - WARMUP: x<=step(x); cnt++. When cnt==WARMUP-1, go to FILL. If WARMUP==0, this state is skipped entirely.
  - FILL: x<=step(x); out_data<=slice(step(x)); out_valid<=1; go to RUN.
  - RUN: if out_valid && out_ready, then x<=step(x), out_data<=slice(step(x)) and sample_count++. Otherwise x and out_data hold.
- First sample after reset or reseed = slice(step^(WARMUP+1)(seed)).
- Reseed (seed_valid=1), accepted in any state:
  - x <= (seed==0) ? SEED : seed; cnt<=0; out_valid<=0.
  - Next state is WARMUP, or FILL if WARMUP==0.
  - Reseed has priority over every other state update in that cycle.
- Handshake coinciding with reseed: a transfer (out_valid && out_ready) in the same cycle as seed_valid still counts as accepted, so sample_count increments. The value then being replaced is not re-presented.
- out_data and all pbits are stable while out_valid=1 and out_ready=0.
- When out_valid=0, pbits are don't-care.
- sample_count wraps modulo 2^CNT_W. It is not cleared by reseed.
- busy = (state != RUN).

## Timing
- Reset values (asynchronous): x=SEED, cnt=0, state=WARMUP (FILL if WARMUP==0), out_valid=0, out_data=0, sample_count=0, busy=1.
- Time from reset deassertion to out_valid=1 is WARMUP+1 rising edges.
- Throughput: one sample per cycle while out_ready is held high. There are no bubbles in RUN.
- Latency from out_ready to the next value: the new sample appears on the edge that completes the transfer.
- Time from reseed to out_valid=1 is WARMUP+2 edges, counting the edge that samples seed_valid.
- Reset asserted mid-operation returns the block to reset values immediately. Any in-flight sample is lost without being counted.
- seed_valid asserted during rst is ignored.
- Outputs are registered. The only combinational path is step(x) into the x and out_data registers.

## Test plan
- Reset sequencing (WARMUP=0, SEED=1, out_ready=1): release rst. out_valid rises on the 1st edge with s=0x40822041. Required values: pbits0=0x41, pbits1=0x8220, pbits2=0x0040, pbits3=0, pbits4=0, pbits5=0, pbits6=0, pbits7=0.
- Warm-up length (default WARMUP=16): out_valid stays 0 and busy=1 for exactly 16 edges after rst release, then rises on the 17th edge. The first sample must equal a software model of step^17(1).
- Backpressure: hold out_ready=0 for 10 cycles while valid. pbits and sample_count must stay frozen. Then pulse out_ready for 1 cycle: exactly one new sample appears and sample_count increments by 1.
- Reseed mid-stream with seed=0, concurrent with a transfer: sample_count increments, out_valid drops next cycle, and the sample stream then restarts identical to the post-reset stream.
- Reset during RUN after 5 transfers: all outputs return to reset values asynchronously and sample_count=0.
- Counter wrap (CNT_W=4): 16 consecutive transfers bring sample_count back to 0. The stream must match the software model throughout.
